reg_bank_ctrl: RTL and testbench

REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

---
 rtl/reg_bank_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/reg_bank_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_reg_bank_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared widths, write-mode codes, FSM encoding and the client command record
// for the register-bank controller.
package reg_bank_pkg;

  localparam int DATA_W      = 64;
  localparam int ADDR_W      = 4;
  localparam int NUM_CLIENTS = 2;

  // endreg codes understood by the bank: 00 writes both 32-bit words,
  // 01 writes only the low word, 10 only the high word, 11 writes both words swapped.
  localparam logic [1:0] MODE_BOTH = 2'b00;
  localparam logic [1:0] MODE_LO   = 2'b01;
  localparam logic [1:0] MODE_HI   = 2'b10;
  localparam logic [1:0] MODE_SWAP = 2'b11;

  // Controller FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // One client's command as presented on its request interface
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wsel;
    logic [1:0]        mode;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] rsel_a;
    logic [ADDR_W-1:0] rsel_b;
    logic              cnst;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector; the "last granted" pointer moves only when the caller accepts a grant.
module rr_arbiter2
  import reg_bank_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] i_req,
  input  logic                   i_advance,
  output logic [NUM_CLIENTS-1:0] o_gnt,
  output logic                   o_last
);

  logic r_last;

  // A lone requester wins; on a tie the client not granted last wins
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  // Pointer starts at client 1 so client 0 wins the first tie after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (i_advance && (|o_gnt)) begin
      r_last <= o_gnt[1];
    end
  end

  assign o_last = r_last;

endmodule

// File: rtl/reg_bank_ctrl.sv
// Two-client front end for a dual-read-port register bank. One operation is in
// flight at a time: a write takes 2 cycles (accept, WRITE), a read 3 (accept,
// READ, RESP). Every output is a flop so bank timing is fixed and glitch free.
module reg_bank_ctrl
  import reg_bank_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  // client 0
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_wsel,
  input  logic [1:0]        c0_mode,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [ADDR_W-1:0] c0_rselA,
  input  logic [ADDR_W-1:0] c0_rselB,
  input  logic              c0_cnst,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdataA,
  output logic [DATA_W-1:0] c0_rdataB,
  // client 1
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_wsel,
  input  logic [1:0]        c1_mode,
  input  logic [DATA_W-1:0] c1_wdata,
  input  logic [ADDR_W-1:0] c1_rselA,
  input  logic [ADDR_W-1:0] c1_rselB,
  input  logic              c1_cnst,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdataA,
  output logic [DATA_W-1:0] c1_rdataB,
  // bank side
  output logic              regwen,
  output logic [DATA_W-1:0] inA,
  output logic [ADDR_W-1:0] selwreg,
  output logic [1:0]        endreg,
  output logic [ADDR_W-1:0] seloutA,
  output logic [ADDR_W-1:0] seloutB,
  output logic              cnstA,
  output logic              cnstB,
  output logic              enrregA,
  output logic              enrregB,
  input  logic [DATA_W-1:0] outA,
  input  logic [DATA_W-1:0] outB
);

  cmd_t                   w_cmd0;
  cmd_t                   w_cmd1;
  cmd_t                   w_win_cmd;
  logic [NUM_CLIENTS-1:0] w_req;
  logic [NUM_CLIENTS-1:0] w_gnt;
  logic                   w_advance;
  logic                   w_owner;

  logic [1:0]             r_state;
  logic                   r_c0_gnt, r_c1_gnt, r_c0_rvalid, r_c1_rvalid;
  logic [DATA_W-1:0]      r_c0_rdata_a, r_c0_rdata_b, r_c1_rdata_a, r_c1_rdata_b;
  logic                   r_regwen, r_cnst_a, r_cnst_b, r_enrreg_a, r_enrreg_b;
  logic [DATA_W-1:0]      r_in_a;
  logic [ADDR_W-1:0]      r_selwreg, r_selout_a, r_selout_b;
  logic [1:0]             r_endreg;

  assign w_cmd0 = '{we: c0_we, wsel: c0_wsel, mode: c0_mode, wdata: c0_wdata,
                    rsel_a: c0_rselA, rsel_b: c0_rselB, cnst: c0_cnst};
  assign w_cmd1 = '{we: c1_we, wsel: c1_wsel, mode: c1_mode, wdata: c1_wdata,
                    rsel_a: c1_rselA, rsel_b: c1_rselB, cnst: c1_cnst};

  assign w_req     = {c1_req, c0_req};
  assign w_advance = (r_state == ST_IDLE) && (|w_req);
  assign w_win_cmd = w_gnt[1] ? w_cmd1 : w_cmd0;

  // The arbiter pointer is updated at acceptance, so for the rest of the
  // operation it names the owner; rvalid/rdata are routed with it.
  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .i_req     (w_req),
    .i_advance (w_advance),
    .o_gnt     (w_gnt),
    .o_last    (w_owner)
  );

  // FSM plus registered outputs: pulses and bank controls default to 0 each cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_c0_gnt     <= 1'b0;
      r_c1_gnt     <= 1'b0;
      r_c0_rvalid  <= 1'b0;
      r_c1_rvalid  <= 1'b0;
      r_c0_rdata_a <= '0;
      r_c0_rdata_b <= '0;
      r_c1_rdata_a <= '0;
      r_c1_rdata_b <= '0;
      r_regwen     <= 1'b0;
      r_in_a       <= '0;
      r_selwreg    <= '0;
      r_endreg     <= '0;
      r_selout_a   <= '0;
      r_selout_b   <= '0;
      r_cnst_a     <= 1'b0;
      r_cnst_b     <= 1'b0;
      r_enrreg_a   <= 1'b0;
      r_enrreg_b   <= 1'b0;
    end else begin
      r_c0_gnt    <= 1'b0;
      r_c1_gnt    <= 1'b0;
      r_c0_rvalid <= 1'b0;
      r_c1_rvalid <= 1'b0;
      r_regwen    <= 1'b0;
      r_in_a      <= '0;
      r_selwreg   <= '0;
      r_endreg    <= '0;
      r_selout_a  <= '0;
      r_selout_b  <= '0;
      r_cnst_a    <= 1'b0;
      r_cnst_b    <= 1'b0;
      r_enrreg_a  <= 1'b0;
      r_enrreg_b  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_c0_gnt <= w_gnt[0];
            r_c1_gnt <= w_gnt[1];
            if (w_win_cmd.we) begin
              r_state   <= ST_WRITE;
              r_regwen  <= 1'b1;
              r_in_a    <= w_win_cmd.wdata;
              r_selwreg <= w_win_cmd.wsel;
              r_endreg  <= w_win_cmd.mode;
            end else begin
              r_state    <= ST_READ;
              r_selout_a <= w_win_cmd.rsel_a;
              r_selout_b <= w_win_cmd.rsel_b;
              r_cnst_a   <= w_win_cmd.cnst;
              r_cnst_b   <= w_win_cmd.cnst;
              r_enrreg_a <= 1'b1;
              r_enrreg_b <= 1'b1;
            end
          end
        end
        ST_WRITE: r_state <= ST_IDLE;
        ST_READ:  r_state <= ST_RESP;
        ST_RESP: begin
          r_state <= ST_IDLE;
          if (w_owner) begin
            r_c1_rvalid  <= 1'b1;
            r_c1_rdata_a <= outA;
            r_c1_rdata_b <= outB;
          end else begin
            r_c0_rvalid  <= 1'b1;
            r_c0_rdata_a <= outA;
            r_c0_rdata_b <= outB;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign c0_gnt    = r_c0_gnt;
  assign c1_gnt    = r_c1_gnt;
  assign c0_rvalid = r_c0_rvalid;
  assign c1_rvalid = r_c1_rvalid;
  assign c0_rdataA = r_c0_rdata_a;
  assign c0_rdataB = r_c0_rdata_b;
  assign c1_rdataA = r_c1_rdata_a;
  assign c1_rdataB = r_c1_rdata_b;
  assign regwen    = r_regwen;
  assign inA       = r_in_a;
  assign selwreg   = r_selwreg;
  assign endreg    = r_endreg;
  assign seloutA   = r_selout_a;
  assign seloutB   = r_selout_b;
  assign cnstA     = r_cnst_a;
  assign cnstB     = r_cnst_b;
  assign enrregA   = r_enrreg_a;
  assign enrregB   = r_enrreg_b;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: a behavioural bank is hung on the bank-side ports,
// a shadow copy of the registers predicts read data, and expected reads are
// queued at grant time and popped when rvalid fires.
module tb_reg_bank_ctrl;
  import reg_bank_pkg::*;

  localparam logic [63:0] BANK_CONST = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c0_req = 0, c0_we = 0, c0_cnst = 0;
  logic [3:0]  c0_wsel = 0, c0_rselA = 0, c0_rselB = 0;
  logic [1:0]  c0_mode = 0;
  logic [63:0] c0_wdata = 0;
  logic        c1_req = 0, c1_we = 0, c1_cnst = 0;
  logic [3:0]  c1_wsel = 0, c1_rselA = 0, c1_rselB = 0;
  logic [1:0]  c1_mode = 0;
  logic [63:0] c1_wdata = 0;
  logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [63:0] c0_rdataA, c0_rdataB, c1_rdataA, c1_rdataB;
  logic        regwen, cnstA, cnstB, enrregA, enrregB;
  logic [63:0] inA, outA, outB;
  logic [3:0]  selwreg, seloutA, seloutB;
  logic [1:0]  endreg;

  typedef struct {
    bit          cl;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] bank_mem [16] = '{default: '0};
  logic [63:0] shadow   [16] = '{default: '0};
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_gnt_cyc = 0;
  int          last_wait = 0;
  bit          tb_last = 1'b1;

  reg_bank_ctrl dut (
    .clock(clock), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_wsel(c0_wsel), .c0_mode(c0_mode),
    .c0_wdata(c0_wdata), .c0_rselA(c0_rselA), .c0_rselB(c0_rselB), .c0_cnst(c0_cnst),
    .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdataA(c0_rdataA), .c0_rdataB(c0_rdataB),
    .c1_req(c1_req), .c1_we(c1_we), .c1_wsel(c1_wsel), .c1_mode(c1_mode),
    .c1_wdata(c1_wdata), .c1_rselA(c1_rselA), .c1_rselB(c1_rselB), .c1_cnst(c1_cnst),
    .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdataA(c1_rdataA), .c1_rdataB(c1_rdataB),
    .regwen(regwen), .inA(inA), .selwreg(selwreg), .endreg(endreg),
    .seloutA(seloutA), .seloutB(seloutB), .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB), .outA(outA), .outB(outB)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [1:0] mode);
    case (mode)
      MODE_LO:   merge = {old[63:32], d[31:0]};
      MODE_HI:   merge = {d[63:32], old[31:0]};
      MODE_SWAP: merge = {d[31:0], d[63:32]};
      default:   merge = d;
    endcase
  endfunction

  // Behavioural bank: write port plus registered dual read ports
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      outA <= '0;
      outB <= '0;
    end else begin
      if (regwen)  bank_mem[selwreg] <= merge(bank_mem[selwreg], inA, endreg);
      if (enrregA) outA <= cnstA ? BANK_CONST : bank_mem[seloutA];
      if (enrregB) outB <= cnstB ? BANK_CONST : bank_mem[seloutB];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic drive_cmd(input bit cl, input bit we, input logic [3:0] wsel,
                           input logic [1:0] mode, input logic [63:0] wdata,
                           input logic [3:0] ra, input logic [3:0] rb, input bit cn);
    if (cl) begin
      c1_we = we; c1_wsel = wsel; c1_mode = mode; c1_wdata = wdata;
      c1_rselA = ra; c1_rselB = rb; c1_cnst = cn;
    end else begin
      c0_we = we; c0_wsel = wsel; c0_mode = mode; c0_wdata = wdata;
      c0_rselA = ra; c0_rselB = rb; c0_cnst = cn;
    end
  endtask

  task automatic set_req(input bit cl, input bit v);
    if (cl) c1_req = v; else c0_req = v;
  endtask

  // Runs one operation starting at a negedge and returns at a negedge:
  // write returns in cycle T+2, read in cycle T+3 (after rvalid is checked).
  task automatic do_op(input bit cl, input bit we, input logic [3:0] wsel,
                       input logic [1:0] mode, input logic [63:0] wdata,
                       input logic [3:0] ra, input logic [3:0] rb, input bit cn);
    int   waited;
    exp_t e;
    logic [63:0] ga, gb;
    logic my_rv, ot_rv;
    drive_cmd(cl, we, wsel, mode, wdata, ra, rb, cn);
    set_req(cl, 1'b1);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!(cl ? c1_gnt : c0_gnt) && waited < 20);
    last_wait = waited;
    n_tests++;
    if ((cl ? c1_gnt : c0_gnt) !== 1'b1) begin
      $display("FAIL gnt_timeout c%0d: gnt=%b after %0d cycles, required 1", cl,
               (cl ? c1_gnt : c0_gnt), waited);
      n_fail++;
      set_req(cl, 1'b0);
      return;
    end
    last_gnt_cyc = cyc;
    tb_last = cl;
    set_req(cl, 1'b0);
    n_tests++;
    if ((cl ? c0_gnt : c1_gnt) !== 1'b0) begin
      $display("FAIL gnt_exclusive c%0d: other gnt=1, required 0", cl);
      n_fail++;
    end
    if (we) begin
      n_tests++;
      if (regwen !== 1'b1 || selwreg !== wsel || inA !== wdata || endreg !== mode ||
          enrregA !== 1'b0 || enrregB !== 1'b0) begin
        $display("FAIL write_cycle c%0d: regwen=%b sel=%h inA=%h end=%b enr=%b%b, required 1 %h %h %b 00",
                 cl, regwen, selwreg, inA, endreg, enrregA, enrregB, wsel, wdata, mode);
        n_fail++;
      end
      shadow[wsel] = merge(shadow[wsel], wdata, mode);
      @(negedge clock);
      n_tests++;
      if (regwen !== 1'b0 || inA !== 64'd0 || selwreg !== 4'd0 || endreg !== 2'd0 ||
          c0_gnt !== 1'b0 || c1_gnt !== 1'b0) begin
        $display("FAIL write_idle c%0d: regwen=%b inA=%h sel=%h end=%b gnt=%b%b, required all 0",
                 cl, regwen, inA, selwreg, endreg, c1_gnt, c0_gnt);
        n_fail++;
      end
    end else begin
      n_tests++;
      if (enrregA !== 1'b1 || enrregB !== 1'b1 || seloutA !== ra || seloutB !== rb ||
          cnstA !== cn || cnstB !== cn || regwen !== 1'b0) begin
        $display("FAIL read_cycle c%0d: enr=%b%b selA=%h selB=%h cnst=%b%b regwen=%b, required 11 %h %h %b%b 0",
                 cl, enrregA, enrregB, seloutA, seloutB, cnstA, cnstB, regwen, ra, rb, cn, cn);
        n_fail++;
      end
      e.cl = cl;
      e.a  = cn ? BANK_CONST : shadow[ra];
      e.b  = cn ? BANK_CONST : shadow[rb];
      exp_q.push_back(e);
      @(negedge clock);
      n_tests++;
      if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0 || enrregA !== 1'b0 || enrregB !== 1'b0 ||
          cnstA !== 1'b0 || seloutA !== 4'd0) begin
        $display("FAIL read_resp c%0d: rvalid=%b%b enr=%b%b cnstA=%b selA=%h, required all 0",
                 cl, c1_rvalid, c0_rvalid, enrregA, enrregB, cnstA, seloutA);
        n_fail++;
      end
      @(negedge clock);
      my_rv = cl ? c1_rvalid : c0_rvalid;
      ot_rv = cl ? c0_rvalid : c1_rvalid;
      n_tests++;
      if (my_rv !== 1'b1 || ot_rv !== 1'b0) begin
        $display("FAIL rvalid_t3 c%0d: owner rvalid=%b other=%b, required 1 0", cl, my_rv, ot_rv);
        n_fail++;
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty c%0d: queue size 0, required 1", cl);
        n_fail++;
      end else begin
        e  = exp_q.pop_front();
        ga = e.cl ? c1_rdataA : c0_rdataA;
        gb = e.cl ? c1_rdataB : c0_rdataB;
        if (ga !== e.a || gb !== e.b) begin
          $display("FAIL rdata c%0d: A=%h B=%h, required A=%h B=%h", e.cl, ga, gb, e.a, e.b);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_tests++;
    if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, regwen, cnstA, cnstB, enrregA, enrregB} !== 9'd0 ||
        inA !== 64'd0 || selwreg !== 4'd0 || endreg !== 2'd0 || seloutA !== 4'd0 || seloutB !== 4'd0) begin
      $display("FAIL reset_ctrl: some control output nonzero (regwen=%b enr=%b%b inA=%h), required 0",
               regwen, enrregA, enrregB, inA);
      n_fail++;
    end
    n_tests++;
    if (c0_rdataA !== 64'd0 || c0_rdataB !== 64'd0 || c1_rdataA !== 64'd0 || c1_rdataB !== 64'd0) begin
      $display("FAIL reset_rdata: %h %h %h %h, required 0", c0_rdataA, c0_rdataB, c1_rdataA, c1_rdataB);
      n_fail++;
    end
    reset = 1'b0;
    tb_last = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    do_op(1'b0, 1'b1, 4'hA, MODE_BOTH, 64'd24, 4'h0, 4'h0, 1'b0);
    do_op(1'b1, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'hA, 4'hB, 1'b0);
    n_tests++;
    if (c1_rdataA !== 64'd24 || c1_rdataB !== 64'd0) begin
      $display("FAIL read_after_write: A=%h B=%h, required 18 and 0", c1_rdataA, c1_rdataB);
      n_fail++;
    end
    // a c0 write and read of the same register must not disturb c1's data
    do_op(1'b0, 1'b1, 4'hA, MODE_BOTH, 64'd99, 4'h0, 4'h0, 1'b0);
    do_op(1'b0, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'hA, 4'hA, 1'b0);
    n_tests++;
    if (c1_rdataA !== 64'd24 || c1_rvalid !== 1'b0) begin
      $display("FAIL rdata_hold c1: A=%h rvalid=%b, required 18 0", c1_rdataA, c1_rvalid);
      n_fail++;
    end
  endtask

  task automatic test_modes();
    do_op(1'b0, 1'b1, 4'h3, MODE_SWAP, 64'h0000_0001_0000_0002, 4'h0, 4'h0, 1'b0);
    do_op(1'b0, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h3, 4'h3, 1'b0);
    n_tests++;
    if (c0_rdataA !== 64'h0000_0002_0000_0001) begin
      $display("FAIL swap_mode: A=%h, required 0000000200000001", c0_rdataA);
      n_fail++;
    end
    do_op(1'b1, 1'b1, 4'h7, MODE_BOTH, 64'h1111_1111_2222_2222, 4'h0, 4'h0, 1'b0);
    do_op(1'b1, 1'b1, 4'h7, MODE_LO,   64'hAAAA_AAAA_BBBB_BBBB, 4'h0, 4'h0, 1'b0);
    do_op(1'b0, 1'b1, 4'h7, MODE_HI,   64'hCCCC_CCCC_DDDD_DDDD, 4'h0, 4'h0, 1'b0);
    do_op(1'b1, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h7, 4'h3, 1'b0);
    n_tests++;
    if (c1_rdataA !== 64'hCCCC_CCCC_BBBB_BBBB) begin
      $display("FAIL partial_modes: A=%h, required CCCCCCCCBBBBBBBB", c1_rdataA);
      n_fail++;
    end
  endtask

  task automatic test_cnst();
    do_op(1'b1, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h3, 4'h7, 1'b1);
    n_tests++;
    if (c1_rdataA !== BANK_CONST || c1_rdataB !== BANK_CONST) begin
      $display("FAIL cnst_read: A=%h B=%h, required %h", c1_rdataA, c1_rdataB, BANK_CONST);
      n_fail++;
    end
  endtask

  task automatic test_alternate();
    int grants = 0;
    int budget = 0;
    bit exp_cl;
    drive_cmd(1'b0, 1'b1, 4'h5, MODE_BOTH, 64'h5555_0000_0000_5555, 4'h0, 4'h0, 1'b0);
    drive_cmd(1'b1, 1'b1, 4'h6, MODE_BOTH, 64'h6666_0000_0000_6666, 4'h0, 4'h0, 1'b0);
    c0_req = 1'b1;
    c1_req = 1'b1;
    exp_cl = ~tb_last;
    while (grants < 4 && budget < 40) begin
      @(negedge clock);
      budget++;
      if (c0_gnt === 1'b1 || c1_gnt === 1'b1) begin
        n_tests++;
        if (c1_gnt !== exp_cl || c0_gnt !== ~exp_cl) begin
          $display("FAIL alt_order grant%0d: gnt=%b%b, required c%0d", grants, c1_gnt, c0_gnt, exp_cl);
          n_fail++;
        end
        n_tests++;
        if (regwen !== 1'b1 || selwreg !== (c1_gnt ? 4'h6 : 4'h5) ||
            inA !== (c1_gnt ? c1_wdata : c0_wdata)) begin
          $display("FAIL alt_owner_data grant%0d: sel=%h inA=%h, required owner's command", grants, selwreg, inA);
          n_fail++;
        end
        if (c1_gnt) shadow[6] = c1_wdata; else shadow[5] = c0_wdata;
        tb_last = c1_gnt;
        exp_cl = ~exp_cl;
        grants++;
      end
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    n_tests++;
    if (grants != 4) begin
      $display("FAIL alt_count: %0d grants, required 4", grants);
      n_fail++;
    end
    @(negedge clock);
    do_op(1'b0, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h5, 4'h6, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c_prev;
    do_op(1'b0, 1'b1, 4'h8, MODE_BOTH, 64'h8888, 4'h0, 4'h0, 1'b0);
    c_prev = last_gnt_cyc;
    do_op(1'b0, 1'b1, 4'h9, MODE_BOTH, 64'h9999, 4'h0, 4'h0, 1'b0);
    n_tests++;
    if (last_gnt_cyc - c_prev != 2) begin
      $display("FAIL write_spacing: %0d cycles, required 2", last_gnt_cyc - c_prev);
      n_fail++;
    end
    c_prev = last_gnt_cyc;
    do_op(1'b1, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h8, 4'h9, 1'b0);
    c_prev = last_gnt_cyc;
    do_op(1'b1, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h9, 4'h8, 1'b0);
    n_tests++;
    if (last_gnt_cyc - c_prev != 3) begin
      $display("FAIL read_spacing: %0d cycles, required 3", last_gnt_cyc - c_prev);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_read();
    int waited = 0;
    bit saw_rv = 1'b0;
    int c_prev;
    drive_cmd(1'b0, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'hA, 4'h3, 1'b0);
    c0_req = 1'b1;
    do begin
      @(negedge clock);
      waited++;
    end while (c0_gnt !== 1'b1 && waited < 20);
    c0_req = 1'b0;
    n_tests++;
    if (enrregA !== 1'b1 || enrregB !== 1'b1) begin
      $display("FAIL rst_pre_read: enr=%b%b, required 11", enrregA, enrregB);
      n_fail++;
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (enrregA !== 1'b0 || enrregB !== 1'b0 || c0_gnt !== 1'b0) begin
      $display("FAIL rst_async: enr=%b%b gnt=%b, required 000", enrregA, enrregB, c0_gnt);
      n_fail++;
    end
    @(negedge clock);
    reset = 1'b0;
    tb_last = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) saw_rv = 1'b1;
    end
    n_tests++;
    if (saw_rv) begin
      $display("FAIL rst_no_rvalid: rvalid seen after abort, required none");
      n_fail++;
    end
    // tie after reset: c0 must win, c1 stays pending and is served next
    drive_cmd(1'b1, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h9, 4'h7, 1'b0);
    c1_req = 1'b1;
    do_op(1'b0, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'hA, 4'h5, 1'b0);
    n_tests++;
    if (last_wait != 1) begin
      $display("FAIL rst_tie_c0: c0 granted after %0d cycles, required 1", last_wait);
      n_fail++;
    end
    c_prev = last_gnt_cyc;
    do_op(1'b1, 1'b0, 4'h0, MODE_BOTH, 64'd0, 4'h9, 4'h7, 1'b0);
    n_tests++;
    if (last_gnt_cyc - c_prev != 3) begin
      $display("FAIL pending_c1: granted %0d cycles after c0, required 3", last_gnt_cyc - c_prev);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_modes();
    test_cnst();
    test_alternate();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
